// File: rtl/dmem_responder.sv
// Data-memory responder: target end of the dmem strobe/complete protocol.
// Doubleword RAM with big-endian 8/16/32/64-bit accesses and programmable wait states.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS   = 1024,
  parameter int unsigned READ_LATENCY  = 1,
  parameter int unsigned WRITE_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] dmem_addr,
  input  logic [63:0] dmem_dout,
  input  logic [1:0]  dmem_width,
  input  logic        dmem_rstrobe,
  input  logic        dmem_wstrobe,
  output logic [63:0] dmem_din,
  output logic        dmem_cycle_complete,
  output logic        dmem_err,
  output logic        busy
);

  localparam int unsigned AW      = $clog2(DEPTH_WORDS);
  localparam int unsigned MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int unsigned CW      = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nx;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nx;
  logic [CW-1:0]   w_lat_m1;
  logic            w_access;

  logic [AW+2:0]   r_addr;
  logic [1:0]      r_width;
  logic [63:0]     r_dout;
  logic            r_rd;
  logic            r_wr;

  logic [63:0]     r_din;
  logic            r_complete;
  logic            r_err;
  logic            r_busy;

  logic [63:0]     r_mem [DEPTH_WORDS];

  logic            w_from_idle;
  logic [AW+2:0]   w_op_addr;
  logic [1:0]      w_op_width;
  logic [63:0]     w_op_dout;
  logic            w_op_rd;
  logic            w_op_wr;
  logic [2:0]      w_lane;
  logic [AW-1:0]   w_idx;
  logic [6:0]      w_lane_sh;
  logic [6:0]      w_hi_shift;
  logic            w_misalign;
  logic            w_fault;
  logic [63:0]     w_word;
  logic [63:0]     w_mask;
  logic [63:0]     w_wdata;
  logic [63:0]     w_rdata;

  // With a latency of 1 the access happens on the strobe edge, so operands come straight from the ports.
  assign w_from_idle = (r_state == S_IDLE);
  assign w_op_addr   = w_from_idle ? dmem_addr[AW+2:0] : r_addr;
  assign w_op_width  = w_from_idle ? dmem_width        : r_width;
  assign w_op_dout   = w_from_idle ? dmem_dout         : r_dout;
  assign w_op_rd     = w_from_idle ? dmem_rstrobe      : r_rd;
  assign w_op_wr     = w_from_idle ? dmem_wstrobe      : r_wr;

  assign w_lane    = w_op_addr[2:0];
  assign w_idx     = w_op_addr[AW+2:3];
  assign w_lane_sh = {1'b0, w_lane, 3'b000};

  always_comb begin
    w_hi_shift = 7'd0;
    w_misalign = 1'b0;
    case (w_op_width)
      2'h0: begin w_hi_shift = 7'd0;  w_misalign = (w_lane != 3'd0);      end
      2'h1: begin w_hi_shift = 7'd32; w_misalign = (w_lane[1:0] != 2'd0); end
      2'h2: begin w_hi_shift = 7'd48; w_misalign = w_lane[0];             end
      default: begin w_hi_shift = 7'd56; w_misalign = 1'b0;               end
    endcase
  end

  assign w_fault  = (w_op_rd & w_op_wr) | w_misalign;
  assign w_word   = r_mem[w_idx];
  // Lane b sits at bits [63-8b -: 8]; shifting by 8b moves it to the MSB.
  assign w_mask   = ({64{1'b1}} << w_hi_shift) >> w_lane_sh;
  assign w_wdata  = (w_op_dout << w_hi_shift) >> w_lane_sh;
  assign w_rdata  = (w_word << w_lane_sh) & ({64{1'b1}} << w_hi_shift);
  assign w_lat_m1 = dmem_rstrobe ? CW'(READ_LATENCY - 1) : CW'(WRITE_LATENCY - 1);

  // Next-state: complete lands in cycle T+L, so WAIT covers T+1..T+L-1.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_access   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (dmem_rstrobe || dmem_wstrobe) begin
          w_cnt_nx = w_lat_m1;
          if (w_lat_m1 == '0) begin
            w_state_nx = S_DONE;
            w_access   = 1'b1;
          end else begin
            w_state_nx = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        w_cnt_nx = r_cnt - CW'(1);
        if (r_cnt <= CW'(1)) begin
          w_state_nx = S_DONE;
          w_access   = 1'b1;
        end
      end
      S_DONE: begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = '0;
      end
      default: begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_din      <= '0;
      r_complete <= 1'b0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_complete <= w_access;
      r_err      <= w_access & w_fault;
      r_busy     <= (w_state_nx != S_IDLE);
      if (w_access && w_op_rd) begin
        r_din <= w_fault ? 64'd0 : w_rdata;
      end
    end
  end

  // Request capture on the strobe-sampling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_width <= 2'd0;
      r_dout  <= 64'd0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
    end else if (w_from_idle && (dmem_rstrobe || dmem_wstrobe)) begin
      r_addr  <= dmem_addr[AW+2:0];
      r_width <= dmem_width;
      r_dout  <= dmem_dout;
      r_rd    <= dmem_rstrobe;
      r_wr    <= dmem_wstrobe;
    end
  end

  always_ff @(posedge clk) begin
    if (w_access && w_op_wr && !w_fault) begin
      r_mem[w_idx] <= (w_word & ~w_mask) | (w_wdata & w_mask);
    end
  end

  assign dmem_din            = r_din;
  assign dmem_cycle_complete = r_complete;
  assign dmem_err            = r_err;
  assign busy                = r_busy;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (latencies 1/1 and 4/3) checked every cycle
// against a byte-array memory model with timing derived from the strobe cycle.
module tb_dmem_responder;

  localparam int unsigned DW = 64;
  localparam int unsigned NB = DW * 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] addr = 64'd0;
  logic [63:0] dout = 64'd0;
  logic [1:0]  width = 2'd0;
  logic        rs [2];
  logic        ws [2];
  logic [63:0] din [2];
  logic        cmpl [2];
  logic        err [2];
  logic        busy [2];

  dmem_responder #(.DEPTH_WORDS(DW), .READ_LATENCY(1), .WRITE_LATENCY(1)) u_a (
    .clk(clk), .rst(rst), .dmem_addr(addr), .dmem_dout(dout), .dmem_width(width),
    .dmem_rstrobe(rs[0]), .dmem_wstrobe(ws[0]), .dmem_din(din[0]),
    .dmem_cycle_complete(cmpl[0]), .dmem_err(err[0]), .busy(busy[0]));

  dmem_responder #(.DEPTH_WORDS(DW), .READ_LATENCY(4), .WRITE_LATENCY(3)) u_b (
    .clk(clk), .rst(rst), .dmem_addr(addr), .dmem_dout(dout), .dmem_width(width),
    .dmem_rstrobe(rs[1]), .dmem_wstrobe(ws[1]), .dmem_din(din[1]),
    .dmem_cycle_complete(cmpl[1]), .dmem_err(err[1]), .busy(busy[1]));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Behavioural model: byte-addressed memory plus one outstanding request per instance.
  logic [7:0]  mmem [2][NB];
  bit          s_act [2];
  int          s_t [2];
  int          s_l [2];
  bit          s_rd [2];
  bit          s_wr [2];
  bit          s_fault [2];
  logic [63:0] s_addr [2];
  logic [63:0] s_dout [2];
  int          s_n [2];
  logic [63:0] exp_din [2] = '{64'd0, 64'd0};

  function automatic int lat(input int i, input bit rd);
    if (i == 0) return 1;
    return rd ? 4 : 3;
  endfunction

  task automatic model_start(input int i, input bit rd, input bit wr,
                             input logic [63:0] a, input logic [1:0] w, input logic [63:0] d);
    s_act[i]   = 1'b1;
    s_t[i]     = cyc;
    s_l[i]     = lat(i, rd);
    s_rd[i]    = rd;
    s_wr[i]    = wr;
    s_addr[i]  = a;
    s_dout[i]  = d;
    s_n[i]     = 8 >> w;
    s_fault[i] = (rd && wr) || ((int'(a[2:0]) % s_n[i]) != 0);
  endtask

  task automatic model_apply(input int i);
    int base;
    logic [63:0] res;
    base = int'(s_addr[i][8:0]);
    if (s_rd[i]) begin
      res = 64'd0;
      if (!s_fault[i])
        for (int j = 0; j < s_n[i]; j++) res[63-8*j -: 8] = mmem[i][base+j];
      exp_din[i] = res;
    end else if (s_wr[i] && !s_fault[i]) begin
      for (int j = 0; j < s_n[i]; j++) mmem[i][base+j] = s_dout[i][8*(s_n[i]-1-j) +: 8];
    end
  endtask

  // Per-cycle comparison of every output of both instances.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit eb;
      bit ec;
      bit ee;
      if (rst) begin
        s_act[i]   = 1'b0;
        exp_din[i] = 64'd0;
        eb = 1'b0;
        ec = 1'b0;
        ee = 1'b0;
      end else begin
        eb = s_act[i] && (cyc > s_t[i]) && (cyc <= s_t[i] + s_l[i]);
        ec = s_act[i] && (cyc == s_t[i] + s_l[i]);
        ee = ec && s_fault[i];
        if (ec) begin
          model_apply(i);
          s_act[i] = 1'b0;
        end
      end
      chk($sformatf("busy[%0d]", i), 64'(busy[i]), 64'(eb));
      chk($sformatf("complete[%0d]", i), 64'(cmpl[i]), 64'(ec));
      chk($sformatf("err[%0d]", i), 64'(err[i]), 64'(ee));
      chk($sformatf("din[%0d]", i), din[i], exp_din[i]);
    end
  end

  // Called at posedge+1; returns at posedge+1 with both instances idle again.
  task automatic access(input logic [1:0] mask, input bit rd, input bit wr,
                        input logic [63:0] a, input logic [1:0] w, input logic [63:0] d,
                        input bit chk_a, input bit exp_err);
    addr  = a;
    width = w;
    dout  = d;
    for (int i = 0; i < 2; i++) begin
      if (mask[i]) begin
        rs[i] = rd;
        ws[i] = wr;
        model_start(i, rd, wr, a, w, d);
      end
    end
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      rs[i] = 1'b0;
      ws[i] = 1'b0;
    end
    if (chk_a) begin
      @(negedge clk);
      chk("lit_a_complete_t1", 64'(cmpl[0]), 64'd1);
      chk("lit_a_err_t1", 64'(err[0]), 64'(exp_err));
    end
    repeat (5) @(posedge clk);
    #1;
  endtask

  initial begin
    int t0;
    int n_c;
    rs = '{1'b0, 1'b0};
    ws = '{1'b0, 1'b0};
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < int'(DW); k++)
      access(2'b11, 1'b0, 1'b1, 64'(k * 8), 2'h0, {$urandom, $urandom}, 1'b0, 1'b0);

    access(2'b11, 1'b0, 1'b1, 64'h10, 2'h0, 64'h0123456789ABCDEF, 1'b1, 1'b0);
    access(2'b11, 1'b1, 1'b0, 64'h10, 2'h0, 64'd0, 1'b1, 1'b0);
    chk("lit_rd64_a", din[0], 64'h0123456789ABCDEF);
    chk("lit_rd64_b", din[1], 64'h0123456789ABCDEF);

    access(2'b11, 1'b0, 1'b1, 64'h20, 2'h0, 64'd0, 1'b0, 1'b0);
    access(2'b11, 1'b0, 1'b1, 64'h23, 2'h3, 64'hFFFFFFFFFFFFFFAA, 1'b0, 1'b0);
    access(2'b11, 1'b1, 1'b0, 64'h20, 2'h0, 64'd0, 1'b0, 1'b0);
    chk("lit_lane_rd64", din[0], 64'h000000AA00000000);
    access(2'b11, 1'b1, 1'b0, 64'h23, 2'h3, 64'd0, 1'b0, 1'b0);
    chk("lit_lane_rd8", din[0], 64'hAA00000000000000);

    access(2'b11, 1'b0, 1'b1, 64'h28, 2'h0, 64'd0, 1'b0, 1'b0);
    access(2'b11, 1'b0, 1'b1, 64'h2A, 2'h2, 64'h000000000000BEEF, 1'b0, 1'b0);
    access(2'b11, 1'b1, 1'b0, 64'h28, 2'h1, 64'd0, 1'b0, 1'b0);
    chk("lit_rd32", din[0], 64'h0000BEEF00000000);
    access(2'b11, 1'b1, 1'b0, 64'h2A, 2'h2, 64'd0, 1'b0, 1'b0);
    chk("lit_rd16", din[1], 64'hBEEF000000000000);

    access(2'b11, 1'b0, 1'b1, 64'h22, 2'h1, 64'h0000000012345678, 1'b1, 1'b1);
    access(2'b11, 1'b1, 1'b0, 64'h20, 2'h0, 64'd0, 1'b0, 1'b0);
    chk("lit_misaligned_nowrite", din[0], 64'h000000AA00000000);
    access(2'b11, 1'b1, 1'b1, 64'h10, 2'h0, 64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b1);
    chk("lit_dual_din0", din[0], 64'd0);

    // Read latency 4 with a second strobe at T+2 that must be ignored.
    addr = 64'h10; width = 2'h0; rs[1] = 1'b1;
    model_start(1, 1'b1, 1'b0, 64'h10, 2'h0, 64'd0);
    t0 = cyc;
    @(posedge clk); #1 rs[1] = 1'b0;
    @(posedge clk); #1 addr = 64'h20; rs[1] = 1'b1;
    @(posedge clk); #1 rs[1] = 1'b0;
    n_c = 0;
    repeat (10) begin
      @(negedge clk);
      if (cmpl[1]) begin
        n_c++;
        chk("lit_lat4_cycle", 64'(cyc - t0), 64'd4);
      end
    end
    chk("lit_single_complete", 64'(n_c), 64'd1);
    chk("lit_lat4_data", din[1], 64'h0123456789ABCDEF);
    @(posedge clk); #1;

    // Reset one cycle into a latency-3 write.
    addr = 64'h10; width = 2'h0; dout = 64'hDEADBEEFCAFEF00D; ws[1] = 1'b1;
    model_start(1, 1'b0, 1'b1, 64'h10, 2'h0, 64'hDEADBEEFCAFEF00D);
    @(posedge clk); #1 ws[1] = 1'b0; rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("lit_rst_din", din[1], 64'd0);
      chk("lit_rst_busy", 64'(busy[1]), 64'd0);
      chk("lit_rst_complete", 64'(cmpl[1]), 64'd0);
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    access(2'b10, 1'b1, 1'b0, 64'h10, 2'h0, 64'd0, 1'b0, 1'b0);
    chk("lit_rst_old_value", din[1], 64'h0123456789ABCDEF);

    for (int k = 0; k < 300; k++) begin
      logic [1:0]  m;
      logic [63:0] a;
      int          r;
      bit          rd;
      bit          wr;
      m = 2'($urandom_range(1, 3));
      a = {$urandom, $urandom};
      a[8:7] = 2'b00;
      r  = int'($urandom_range(0, 19));
      rd = (r < 9) || (r >= 18);
      wr = (r >= 9);
      access(m, rd, wr, a, 2'($urandom_range(0, 3)), {$urandom, $urandom}, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
